// File: rtl/vector_shift_scheduler.sv
// Issue controller sharing one pipelined vector shift unit between NUM_REQ requesters.
// Each accepted instruction becomes LMUL single-register micro-ops tracked to writeback by a tag pipe.
module vector_shift_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int LATENCY    = 3,
  parameter int REG_ADDR_W = 5,
  parameter int EXEC_W     = 16,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0][EXEC_W-1:0]    req_execution_vector,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_vs2_addr,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_vs1_addr,
  input  logic [NUM_REQ-1:0][REG_ADDR_W-1:0] req_vd_addr,
  input  logic [NUM_REQ-1:0][1:0]           req_lmul,
  output logic                              issue_valid,
  output logic [EXEC_W-1:0]                 issue_execution_vector,
  output logic [REG_ADDR_W-1:0]             issue_vs2_addr,
  output logic [REG_ADDR_W-1:0]             issue_vs1_addr,
  output logic                              wb_valid,
  output logic [REG_ADDR_W-1:0]             wb_vd_addr,
  output logic [ID_W-1:0]                   wb_req_id,
  output logic [NUM_REQ-1:0]                done,
  output logic                              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       id_q;
  logic [EXEC_W-1:0]     op_q;
  logic [REG_ADDR_W-1:0] vs2_q;
  logic [REG_ADDR_W-1:0] vs1_q;
  logic [REG_ADDR_W-1:0] vd_q;
  logic [2:0]            cnt_q;
  logic [2:0]            lastK_q;
  logic                  issueValid_q;

  logic [LATENCY-1:0]    tagValid_q;
  logic [LATENCY-1:0]    tagLast_q;
  logic [REG_ADDR_W-1:0] tagVd_q [LATENCY];
  logic [ID_W-1:0]       tagId_q [LATENCY];

  logic                  grantAny;
  logic                  highAny;
  logic [ID_W-1:0]       highIdx;
  logic [ID_W-1:0]       lowIdx;
  logic [ID_W-1:0]       grantIdx;
  logic [ID_W-1:0]       ptr_d;
  logic [2:0]            grantLastK;
  logic                  acceptGo;
  logic                  lastOut;
  logic                  issueLast;

  // Round-robin: lowest valid index at/after the pointer, else lowest valid index overall.
  always_comb begin
    highAny  = 1'b0;
    highIdx  = '0;
    lowIdx   = '0;
    grantAny = |req_valid;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (req_valid[j]) begin
        lowIdx = ID_W'(j);
        if (ID_W'(j) >= ptr_q) begin
          highAny = 1'b1;
          highIdx = ID_W'(j);
        end
      end
    end
    grantIdx = highAny ? highIdx : lowIdx;
  end

  always_comb begin
    grantLastK = 3'd0;
    case (req_lmul[grantIdx])
      2'b00:   grantLastK = 3'd0;
      2'b01:   grantLastK = 3'd1;
      2'b10:   grantLastK = 3'd3;
      default: grantLastK = 3'd7;
    endcase
  end

  assign ptr_d     = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
  assign acceptGo  = (state_q == IDLE) && grantAny && !reset;
  assign req_ready = acceptGo ? (NUM_REQ'(1) << grantIdx) : '0;
  assign issueLast = issueValid_q && (cnt_q == lastK_q);
  assign lastOut   = tagValid_q[LATENCY-1] && tagLast_q[LATENCY-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      id_q         <= '0;
      op_q         <= '0;
      vs2_q        <= '0;
      vs1_q        <= '0;
      vd_q         <= '0;
      cnt_q        <= '0;
      lastK_q      <= '0;
      issueValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grantAny) begin
            state_q      <= ISSUE;
            ptr_q        <= ptr_d;
            id_q         <= grantIdx;
            op_q         <= req_execution_vector[grantIdx];
            vs2_q        <= req_vs2_addr[grantIdx];
            vs1_q        <= req_vs1_addr[grantIdx];
            vd_q         <= req_vd_addr[grantIdx];
            cnt_q        <= '0;
            lastK_q      <= grantLastK;
            issueValid_q <= 1'b1;
          end
        end
        ISSUE: begin
          // Register addresses wrap naturally at 2^REG_ADDR_W; group alignment is not enforced.
          vs2_q <= vs2_q + REG_ADDR_W'(1);
          vs1_q <= vs1_q + REG_ADDR_W'(1);
          vd_q  <= vd_q + REG_ADDR_W'(1);
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == lastK_q) begin
            state_q      <= DRAIN;
            issueValid_q <= 1'b0;
          end
        end
        DRAIN: begin
          if (lastOut) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // One stage per cycle of register read plus shift latency; the tail drives writeback.
  always_ff @(posedge clock) begin
    if (reset) begin
      tagValid_q <= '0;
      tagLast_q  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tagVd_q[i] <= '0;
        tagId_q[i] <= '0;
      end
    end else begin
      tagValid_q[0] <= issueValid_q;
      tagLast_q[0]  <= issueLast;
      tagVd_q[0]    <= vd_q;
      tagId_q[0]    <= id_q;
      for (int i = 1; i < LATENCY; i++) begin
        tagValid_q[i] <= tagValid_q[i-1];
        tagLast_q[i]  <= tagLast_q[i-1];
        tagVd_q[i]    <= tagVd_q[i-1];
        tagId_q[i]    <= tagId_q[i-1];
      end
    end
  end

  assign issue_valid            = issueValid_q;
  assign issue_execution_vector = op_q;
  assign issue_vs2_addr         = vs2_q;
  assign issue_vs1_addr         = vs1_q;
  assign wb_valid               = tagValid_q[LATENCY-1];
  assign wb_vd_addr             = tagVd_q[LATENCY-1];
  assign wb_req_id              = tagId_q[LATENCY-1];
  assign done                   = lastOut ? (NUM_REQ'(1) << tagId_q[LATENCY-1]) : '0;
  assign busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_vector_shift_scheduler.sv
// Scoreboard bench for vector_shift_scheduler: a cycle-stamped reference model predicts every
// grant, micro-op and writeback; a monitor pops and compares whenever the DUT presents them.
module tb_vector_shift_scheduler;
  localparam int NUM_REQ = 2;
  localparam int LATENCY = 3;
  localparam int AW      = 5;
  localparam int EW      = 16;
  localparam int IDW     = 1;

  bit clock = 1'b0;
  logic reset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0][EW-1:0]  req_execution_vector;
  logic [NUM_REQ-1:0][AW-1:0]  req_vs2_addr;
  logic [NUM_REQ-1:0][AW-1:0]  req_vs1_addr;
  logic [NUM_REQ-1:0][AW-1:0]  req_vd_addr;
  logic [NUM_REQ-1:0][1:0]     req_lmul;
  logic                        issue_valid;
  logic [EW-1:0]               issue_execution_vector;
  logic [AW-1:0]               issue_vs2_addr;
  logic [AW-1:0]               issue_vs1_addr;
  logic                        wb_valid;
  logic [AW-1:0]               wb_vd_addr;
  logic [IDW-1:0]              wb_req_id;
  logic [NUM_REQ-1:0]          done;
  logic                        busy;

  vector_shift_scheduler #(
    .NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .REG_ADDR_W(AW), .EXEC_W(EW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_execution_vector(req_execution_vector),
    .req_vs2_addr(req_vs2_addr), .req_vs1_addr(req_vs1_addr), .req_vd_addr(req_vd_addr),
    .req_lmul(req_lmul),
    .issue_valid(issue_valid), .issue_execution_vector(issue_execution_vector),
    .issue_vs2_addr(issue_vs2_addr), .issue_vs1_addr(issue_vs1_addr),
    .wb_valid(wb_valid), .wb_vd_addr(wb_vd_addr), .wb_req_id(wb_req_id),
    .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { int cyc; int vs2; int vs1; int op; } issueExp_t;
  typedef struct { int cyc; int vd; int id; bit last; } wbExp_t;

  issueExp_t issueQ[$];
  wbExp_t    wbQ[$];
  int grantLog[$];
  int acceptCycLog[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int ptrModel   = 0;
  int acceptT    = -1;
  int busyUntil  = -1;
  logic [NUM_REQ-1:0] lastAccept = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int modelGrant(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int o = 0; o < NUM_REQ; o++) begin
      if (v[(ptr + o) % NUM_REQ]) return (ptr + o) % NUM_REQ;
    end
    return -1;
  endfunction

  // Reset drops every expectation the moment the DUT sees it.
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      issueQ.delete();
      wbQ.delete();
      ptrModel  = 0;
      acceptT   = -1;
      busyUntil = -1;
    end
  end

  // Predictor: decides the grant from the arbitration rules and pushes the resulting schedule.
  always @(negedge clock) begin
    int g;
    int n;
    logic [NUM_REQ-1:0] expReady;
    issueExp_t ie;
    wbExp_t we;
    if (cyc > 0) begin
      checkOutput("busy", busy, (cyc > acceptT && cyc <= busyUntil) ? 1 : 0);
      lastAccept = '0;
      if (!reset) begin
        expReady = '0;
        g = -1;
        if (cyc > busyUntil) g = modelGrant(req_valid, ptrModel);
        if (g >= 0) expReady[g] = 1'b1;
        checkOutput("req_ready", req_ready, expReady);
        lastAccept = req_valid & req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (lastAccept[i]) begin
            grantLog.push_back(i);
            acceptCycLog.push_back(cyc);
          end
        end
        if (g >= 0) begin
          n = 1 << req_lmul[g];
          for (int k = 0; k < n; k++) begin
            ie.cyc  = cyc + 1 + k;
            ie.vs2  = (int'(req_vs2_addr[g]) + k) % (1 << AW);
            ie.vs1  = (int'(req_vs1_addr[g]) + k) % (1 << AW);
            ie.op   = int'(req_execution_vector[g]);
            issueQ.push_back(ie);
            we.cyc  = cyc + 1 + k + LATENCY;
            we.vd   = (int'(req_vd_addr[g]) + k) % (1 << AW);
            we.id   = g;
            we.last = (k == n - 1);
            wbQ.push_back(we);
          end
          acceptT   = cyc;
          busyUntil = cyc + n + LATENCY;
          ptrModel  = (g + 1) % NUM_REQ;
        end
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the head of each queue.
  always begin
    issueExp_t ie;
    wbExp_t we;
    @(negedge clock);
    #1;
    if (cyc > 0) begin
      if (issue_valid === 1'b1) begin
        if (issueQ.size() == 0) checkOutput("issue_unexpected", issue_valid, 0);
        else begin
          ie = issueQ.pop_front();
          checkOutput("issue_cycle", cyc, ie.cyc);
          checkOutput("issue_vs2", issue_vs2_addr, ie.vs2);
          checkOutput("issue_vs1", issue_vs1_addr, ie.vs1);
          checkOutput("issue_op", issue_execution_vector, ie.op);
        end
      end else if (issueQ.size() > 0 && issueQ[0].cyc <= cyc) begin
        ie = issueQ.pop_front();
        checkOutput("issue_missing", issue_valid, 1);
      end
      if (wb_valid === 1'b1) begin
        if (wbQ.size() == 0) begin
          checkOutput("wb_unexpected", wb_valid, 0);
          checkOutput("done_unexpected", done, 0);
        end else begin
          we = wbQ.pop_front();
          checkOutput("wb_cycle", cyc, we.cyc);
          checkOutput("wb_vd", wb_vd_addr, we.vd);
          checkOutput("wb_id", wb_req_id, we.id);
          checkOutput("done", done, we.last ? (1 << we.id) : 0);
        end
      end else begin
        if (wbQ.size() > 0 && wbQ[0].cyc <= cyc) begin
          we = wbQ.pop_front();
          checkOutput("wb_missing", wb_valid, 1);
        end
        checkOutput("done_idle", done, 0);
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic setFields(input int id, input int op, input int vs2, input int vs1,
                           input int vd, input int lmul);
    req_execution_vector[id] = EW'(op);
    req_vs2_addr[id]         = AW'(vs2);
    req_vs1_addr[id]         = AW'(vs1);
    req_vd_addr[id]          = AW'(vd);
    req_lmul[id]             = 2'(lmul);
  endtask

  // Offers one instruction and holds it until the DUT accepts it.
  task automatic applyStimulus(input int id, input int op, input int vs2, input int vs1,
                               input int vd, input int lmul);
    bit got;
    setFields(id, op, vs2, vs1, vd, lmul);
    req_valid[id] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 100 && !got; t++) begin
      waitCycles(1);
      if (lastAccept[id]) begin
        req_valid[id] = 1'b0;
        got = 1'b1;
      end
    end
    if (!got) req_valid[id] = 1'b0;
    checkOutput("accept_timeout", got, 1);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    reset = 1'b1;
    req_valid = '0;
    req_execution_vector = '0;
    req_vs2_addr = '0;
    req_vs1_addr = '0;
    req_vd_addr = '0;
    req_lmul = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_issue_valid", issue_valid, 0);
    checkOutput("reset_wb_valid", wb_valid, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_req_ready", req_ready, 0);

    $display("[TB] single LMUL=1 instruction");
    applyStimulus(0, 16'h00a1, 4, 8, 12, 0);
    waitCycles(8);

    $display("[TB] LMUL=8 with address wrap");
    applyStimulus(1, 16'h0b22, 28, 0, 30, 3);
    waitCycles(14);

    $display("[TB] contention held from reset");
    reset = 1'b1;
    setFields(0, 16'h0111, 1, 2, 3, 0);
    setFields(1, 16'h0222, 5, 6, 7, 0);
    req_valid = 2'b11;
    waitCycles(2);
    reset = 1'b0;
    s = grantLog.size();
    for (int t = 0; t < 80 && grantLog.size() < s + 3; t++) waitCycles(1);
    req_valid = '0;
    checkOutput("contention_grants", grantLog.size() - s, 3);
    if (grantLog.size() >= s + 3) begin
      checkOutput("contention_first", grantLog[s], 0);
      checkOutput("contention_second", grantLog[s+1], 1);
      checkOutput("contention_third", grantLog[s+2], 0);
    end
    waitCycles(8);

    $display("[TB] back-to-back LMUL=2");
    setFields(0, 16'h0333, 9, 17, 25, 1);
    req_valid[0] = 1'b1;
    s = acceptCycLog.size();
    for (int t = 0; t < 60 && acceptCycLog.size() < s + 2; t++) waitCycles(1);
    req_valid[0] = 1'b0;
    checkOutput("b2b_accepts", acceptCycLog.size() - s, 2);
    if (acceptCycLog.size() >= s + 2)
      checkOutput("b2b_gap", acceptCycLog[s+1] - acceptCycLog[s], 6);
    waitCycles(10);

    $display("[TB] reset during ISSUE");
    applyStimulus(0, 16'h0444, 10, 20, 5, 2);
    waitCycles(2);
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    checkOutput("rst_issue_valid", issue_valid, 0);
    checkOutput("rst_wb_valid", wb_valid, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_busy", busy, 0);
    waitCycles(10);

    $display("[TB] idle hold");
    for (int t = 0; t < 20; t++) begin
      waitCycles(1);
      checkOutput("idle_issue_valid", issue_valid, 0);
      checkOutput("idle_wb_valid", wb_valid, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
    end

    $display("[TB] randomized traffic");
    for (int t = 0; t < 800; t++) begin
      waitCycles(1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (lastAccept[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          setFields(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 3)));
          req_valid[i] = 1'b1;
        end
      end
    end
    req_valid = '0;
    waitCycles(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/vector_shift_scheduler.md
# vector_shift_scheduler

Issue controller that shares the pipelined vector shift unit between `NUM_REQ` requesters. It arbitrates round-robin among pending shift instructions and expands each accepted instruction into `LMUL` single-register micro-ops on consecutive register addresses. It tracks every micro-op through the fixed-latency register-read plus shift pipeline, and emits writeback strobes and a per-requester completion pulse. It sits between the vector issue stage and the register-file read port that feeds the shift unit's `vs2`/`vs1` inputs.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters.
- `LATENCY`, 3: cycles from micro-op issue to result at the register-file write port (1 register read + 2 shift unit).
- `REG_ADDR_W`, 5: vector register address width.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  requester holds an instruction.
- `req_ready`  out  NUM_REQ  one-hot accept strobe; transfer occurs when valid && ready.
- `req_execution_vector`  in  NUM_REQ x execution_vector_t  decoded shift operation.
- `req_vs2_addr`, `req_vs1_addr`, `req_vd_addr`  in  NUM_REQ x REG_ADDR_W  base register addresses.
- `req_lmul`  in  NUM_REQ x 2  register group size: 00=1, 01=2, 10=4, 11=8.
- `issue_valid`  out  1  micro-op presented to register read and the shift unit this cycle.
- `issue_execution_vector`  out  execution_vector_t  operation of the current micro-op.
- `issue_vs2_addr`, `issue_vs1_addr`  out  REG_ADDR_W  source register addresses.
- `wb_valid`  out  1  shift result is at the write port this cycle.
- `wb_vd_addr`  out  REG_ADDR_W  destination register for the result.
- `wb_req_id`  out  $clog2(NUM_REQ)  owner of the result.
- `done`  out  NUM_REQ  one-cycle pulse on the last writeback of an instruction.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- Reset: state IDLE and round-robin priority pointer set to 0. All in-flight tags are cleared. Every output is 0.
- State machine has three states: IDLE, ISSUE and DRAIN.
- IDLE:
  - If any `req_valid` is high, grant the first valid requester at or after the priority pointer (wrapping).
  - Assert `req_ready` for the granted requester only, combinationally, in the same cycle.
  - Capture that requester's operation, addresses, lmul and id.
  - Set the priority pointer to (grant+1) mod NUM_REQ.
  - Go to ISSUE.
- ISSUE:
  - Each cycle, present micro-op k (k = 0..N-1, N = 1<<lmul) with `issue_valid`=1.
  - Source addresses are `vs2`+k and `vs1`+k, mod 2^REG_ADDR_W (wrap 31→0).
  - Push a tag {vd+k mod 2^REG_ADDR_W, id, last=(k==N-1)} into a LATENCY-deep shift register.
  - After k = N-1, go to DRAIN.
- DRAIN:
  - `issue_valid`=0.
  - When the tag with last=1 emerges, pulse `done[id]` and return to IDLE.
- Tag pipeline output drives `wb_valid`, `wb_vd_addr` and `wb_req_id` directly. Writebacks cannot be stalled.
- `req_ready` is 0 outside IDLE. A pending requester must hold `req_valid` and its fields stable until accepted.
- Instructions never overlap, so there is no read-after-write hazard between consecutive instructions.
- Register-group alignment is not checked. Misaligned bases wrap as specified.

## Timing
- Accept in cycle T. Micro-op k issues in cycle T+1+k. Its writeback occurs in cycle T+1+k+LATENCY.
- `done` pulses in cycle T+N+LATENCY, coincident with the last `wb_valid`.
- The state is IDLE in cycle T+N+LATENCY+1, and the next accept may happen in that cycle.
- Occupancy per instruction is N+LATENCY+1 cycles.
- Simultaneous `req_valid` from several requesters: only one is granted per accept, chosen by the pointer. The others see `req_ready`=0.
- Reset asserted in any state takes effect at the next edge:
  - All tags are dropped.
  - `wb_valid`, `done`, `issue_valid` and `busy` are 0 in the following cycle.
  - Partially issued micro-ops never write back.

## Test plan
- Single instruction with LMUL=1: req0, vs2=4, vs1=8, vd=12, accepted at T. Required: `issue_valid` at T+1 with addresses 4/8; `wb_valid` with vd=12, id=0 and `done[0]` at T+4; `busy` low at T+5.
- Wrap with LMUL=8: req1, vs2=28, vs1=0, vd=30. Required:
  - Issue addresses 28,29,30,31,0,1,2,3 with vs1 0..7 over T+1..T+8.
  - wb vd 30,31,0..5 over T+4..T+11.
  - `done[1]` at T+11 only.
- Contention: both valid and held from reset. Required: req0 granted first, then req1, then req0 (`req_ready` one-hot, never both high).
- Back-to-back: req0 LMUL=2 accepted at T while req0 `req_valid` stays high. Required: next accept exactly at T+6; no `req_ready` at T+1..T+5.
- Reset mid-ISSUE: LMUL=4 job, `reset` high for the cycle after micro-op 1 issues. Required: all outputs 0 next cycle; no `wb_valid` or `done` afterwards until a new accept.
- Idle hold: `req_valid` low for 20 cycles. Required: `issue_valid`, `wb_valid`, `busy` and `done` stay 0.
